// File: rtl/ram_pkg.sv
// Shared definitions for the pipelined NoC RAM endpoint: request field layout,
// response record, configuration legality and counter helpers.
package ram_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_ADDR_WIDTH   = 7;
    localparam int DEF_N            = 16;
    localparam int DEF_N_ADDR_WIDTH = $clog2(DEF_N);

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef struct packed {
        logic [DEF_N_ADDR_WIDTH-1:0] src;
        logic [DEF_WIDTH-1:0]        data;
    } rsp_t;

    // Request layout, MSB->LSB: {wr, rd, src, addr, wdata}
    function automatic int addr_lsb(input int width);
        return width;
    endfunction

    function automatic int src_lsb(input int width, input int addr_width);
        return width + addr_width;
    endfunction

    function automatic int rd_bit(input int packed_in);
        return packed_in - 2;
    endfunction

    function automatic int wr_bit(input int packed_in);
        return packed_in - 1;
    endfunction

    function automatic bit cfg_legal(input int rd_lat, input int rsp_depth,
                                     input int node, input int n);
        return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX) &&
               (rsp_depth >= rd_lat) && (rsp_depth >= 2) &&
               ((rsp_depth & (rsp_depth - 1)) == 0) && (node < n);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Circular response FIFO; pointers carry an extra MSB so full and empty are
// distinguished by comparing pointers. The head is read combinationally.
module ram_rsp_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             pop_ok;

    assign o_count = wr_ptr_q - rd_ptr_q;
    assign pop_ok  = i_pop && (o_count != '0);
    assign o_head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; pointer reset alone empties the FIFO.
    always_ff @(posedge clk) begin
        if (i_push) mem_q[wr_ptr_q[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/ram_pipelined.sv
// NoC RAM endpoint: single-port memory with a fixed-latency read pipeline,
// credit-reserved response FIFO, optional write acks and saturating statistics.
module ram_pipelined
    import ram_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int ADDR_WIDTH   = 7,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NODE         = 15,
    parameter int RD_LAT       = 2,
    parameter int RSP_DEPTH    = 8,
    parameter int WR_ACK       = 0,
    parameter int PACKED_IN    = WIDTH + ADDR_WIDTH + N_ADDR_WIDTH + 2,
    parameter int PACKED_OUT   = WIDTH + N_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PACKED_IN-1:0]    i_packed_in,
    input  logic                    i_valid_in,
    output logic                    i_ready_out,
    output logic [PACKED_OUT-1:0]   o_packed_out,
    output logic [N_ADDR_WIDTH-1:0] o_dest_out,
    output logic                    o_valid_out,
    input  logic                    o_ready_in,
    output logic [15:0]             o_rd_count,
    output logic [15:0]             o_wr_count,
    output logic [15:0]             o_drop_count
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int CW       = $clog2(RSP_DEPTH + 1);
    localparam int FCW      = $clog2(RSP_DEPTH) + 1;
    localparam int ADDR_LSB = addr_lsb(WIDTH);
    localparam int SRC_LSB  = src_lsb(WIDTH, ADDR_WIDTH);
    localparam int RD_BIT   = rd_bit(PACKED_IN);
    localparam int WR_BIT   = wr_bit(PACKED_IN);

    if (!cfg_legal(RD_LAT, RSP_DEPTH, NODE, N)) begin : g_bad_cfg
        $error("ram_pipelined: illegal RD_LAT/RSP_DEPTH/NODE combination");
    end

    // Handshakes: a transfer happens on a clock edge where valid && ready.
    // Ready never looks at valid; valid, once raised, holds its payload
    // stable until the transfer completes.

    logic                    req_wr, req_rd;
    logic [N_ADDR_WIDTH-1:0] req_src;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [WIDTH-1:0]        req_wdata;
    logic                    accept, rsp_gen, rsp_pop;
    logic [PACKED_OUT-1:0]   rsp_new;
    logic                    rsp_push;
    logic [PACKED_OUT-1:0]   rsp_push_data;
    logic [PACKED_OUT-1:0]   fifo_head;
    logic [FCW-1:0]          fifo_count;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    credit_q, credit_d;
    logic [15:0]      rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, drop_cnt_q, drop_cnt_d;

    assign req_wr    = i_packed_in[WR_BIT];
    assign req_rd    = i_packed_in[RD_BIT];
    assign req_src   = i_packed_in[SRC_LSB +: N_ADDR_WIDTH];
    assign req_addr  = i_packed_in[ADDR_LSB +: ADDR_WIDTH];
    assign req_wdata = i_packed_in[0 +: WIDTH];

    assign i_ready_out = !rst && (credit_q != '0);
    assign accept      = i_valid_in && i_ready_out;
    assign rsp_gen     = accept && (req_rd || (req_wr && (WR_ACK != 0)));
    assign rsp_pop     = o_valid_out && o_ready_in;

    // Reading before the write edge gives read-before-write for rd&wr requests.
    assign rsp_new = {req_src, req_rd ? mem_q[req_addr] : req_wdata};

    always_ff @(posedge clk) begin
        if (accept && req_wr) mem_q[req_addr] <= req_wdata;
    end

    // RD_LAT-1 register stages, then one FIFO write cycle before o_valid_out.
    if (RD_LAT == 1) begin : g_no_pipe
        assign rsp_push      = rsp_gen;
        assign rsp_push_data = rsp_new;
    end else begin : g_pipe
        localparam int STAGES = RD_LAT - 1;
        logic [STAGES-1:0]     vld_q, vld_d;
        logic [PACKED_OUT-1:0] dat_q [STAGES];
        logic [PACKED_OUT-1:0] dat_d [STAGES];

        always_comb begin
            vld_d[0] = rsp_gen;
            dat_d[0] = rsp_new;
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
                dat_d[s] = dat_q[s-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                for (int s = 0; s < STAGES; s++) dat_q[s] <= '0;
            end else begin
                vld_q <= vld_d;
                for (int s = 0; s < STAGES; s++) dat_q[s] <= dat_d[s];
            end
        end

        assign rsp_push      = vld_q[STAGES-1];
        assign rsp_push_data = dat_q[STAGES-1];
    end

    ram_rsp_fifo #(
        .WIDTH (PACKED_OUT),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (rsp_push),
        .i_push_data (rsp_push_data),
        .i_pop       (rsp_pop),
        .o_head      (fifo_head),
        .o_count     (fifo_count)
    );

    assign o_valid_out  = (fifo_count != '0);
    assign o_packed_out = o_valid_out ? fifo_head : '0;
    assign o_dest_out   = o_packed_out[PACKED_OUT-1 -: N_ADDR_WIDTH];

    // A credit is held from accept until the response leaves the FIFO.
    always_comb begin
        credit_d = credit_q;
        if (rsp_gen && !rsp_pop)      credit_d = credit_q - CW'(1);
        else if (!rsp_gen && rsp_pop) credit_d = credit_q + CW'(1);
    end

    always_comb begin
        rd_cnt_d   = sat_inc(rd_cnt_q,   accept && req_rd);
        wr_cnt_d   = sat_inc(wr_cnt_q,   accept && req_wr);
        drop_cnt_d = sat_inc(drop_cnt_q, accept && !req_rd && !req_wr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q   <= CW'(RSP_DEPTH);
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            credit_q   <= credit_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_rd_count   = rd_cnt_q;
    assign o_wr_count   = wr_cnt_q;
    assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_ram_pipelined.sv
// Bench for ram_pipelined: two instances (no write ack / write ack) checked
// against a behavioural memory model through per-instance expected queues.
module tb_ram_pipelined;

    localparam int W    = 8;
    localparam int AW   = 7;
    localparam int NW   = 4;
    localparam int LAT  = 2;
    localparam int RD   = 8;
    localparam int PI   = W + AW + NW + 2;
    localparam int PO   = W + NW;
    localparam int MD   = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [PI-1:0] pin    [2];
    logic          vin    [2];
    logic          rdy_out[2];
    logic [PO-1:0] pout   [2];
    logic [NW-1:0] dest   [2];
    logic          vout   [2];
    logic          rdy_in [2];
    logic [15:0]   rdc    [2];
    logic [15:0]   wrc    [2];
    logic [15:0]   drc    [2];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    ram_pipelined #(.WIDTH(W), .ADDR_WIDTH(AW), .N(16), .NODE(15), .RD_LAT(LAT),
                    .RSP_DEPTH(RD), .WR_ACK(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_packed_in(pin[0]), .i_valid_in(vin[0]),
        .i_ready_out(rdy_out[0]), .o_packed_out(pout[0]), .o_dest_out(dest[0]),
        .o_valid_out(vout[0]), .o_ready_in(rdy_in[0]), .o_rd_count(rdc[0]),
        .o_wr_count(wrc[0]), .o_drop_count(drc[0]));

    ram_pipelined #(.WIDTH(W), .ADDR_WIDTH(AW), .N(16), .NODE(15), .RD_LAT(LAT),
                    .RSP_DEPTH(RD), .WR_ACK(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_packed_in(pin[1]), .i_valid_in(vin[1]),
        .i_ready_out(rdy_out[1]), .o_packed_out(pout[1]), .o_dest_out(dest[1]),
        .o_valid_out(vout[1]), .o_ready_in(rdy_in[1]), .o_rd_count(rdc[1]),
        .o_wr_count(wrc[1]), .o_drop_count(drc[1]));

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0]  ref_mem[2][MD];
    logic [PO-1:0] exp_q0[$];
    logic [PO-1:0] exp_q1[$];
    int            m_rd[2], m_wr[2], m_drop[2];
    int            n_pops[2], acc_cyc[2], pop_cyc[2];
    int            rdy_mode[2];
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push_exp(input int k, input logic [PO-1:0] v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic send(input int k, input bit wr, input bit rd, input logic [NW-1:0] src,
                        input logic [AW-1:0] addr, input logic [W-1:0] data);
        int waited = 0;
        pin[k] = {wr, rd, src, addr, data};
        vin[k] = 1'b1;
        @(negedge clk);
        while (!rdy_out[k] && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy_out[k]) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout inst%0d: ready stayed 0 for %0d cycles", k, waited);
            vin[k] = 1'b0;
            return;
        end
        acc_cyc[k] = cyc;
        if (rd)                   push_exp(k, {src, ref_mem[k][addr]});
        else if (wr && (k == 1))  push_exp(k, {src, data});
        if (wr) ref_mem[k][addr] = data;
        if (rd) m_rd[k]++;
        if (wr) m_wr[k]++;
        if (!rd && !wr) m_drop[k]++;
        @(posedge clk);
        #1;
        vin[k] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || vout[0] || vout[1]) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_q0", 64'(exp_q0.size()), 64'd0);
        chk("drain_q1", 64'(exp_q1.size()), 64'd0);
    endtask

    task automatic rand_op(input int k);
        int op = $urandom_range(0, 7);
        logic [NW-1:0] s = NW'($urandom_range(0, 15));
        logic [AW-1:0] a = AW'($urandom_range(0, 15));
        logic [W-1:0]  d = W'($urandom_range(0, 255));
        if (op == 0)      send(k, 1'b0, 1'b0, s, a, d);
        else if (op <= 3) send(k, 1'b0, 1'b1, s, a, d);
        else if (op <= 5) send(k, 1'b1, 1'b0, s, a, d);
        else              send(k, 1'b1, 1'b1, s, a, d);
    endtask

    // ---------------- downstream ready ----------------
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rdy_mode[k] == 0)      rdy_in[k] = 1'b1;
            else if (rdy_mode[k] == 1) rdy_in[k] = 1'b0;
            else                       rdy_in[k] = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor ----------------
    logic          stall_prev[2];
    logic [PO+NW-1:0] prev_out[2];

    always @(negedge clk) begin
        logic [PO-1:0] e;
        if (!rst) begin
            if (u_dut0.rsp_push) chk("no_push_full0", 64'(u_dut0.u_fifo.o_count == RD), 64'd0);
            if (u_dut1.rsp_push) chk("no_push_full1", 64'(u_dut1.u_fifo.o_count == RD), 64'd0);
        end
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                stall_prev[k] = 1'b0;
            end else begin
                if (stall_prev[k]) chk("hold_stable", {dest[k], pout[k]}, prev_out[k]);
                if (vout[k] && rdy_in[k]) begin
                    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_rsp inst%0d: got 0x%0h expected none", k, pout[k]);
                    end else begin
                        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk("rsp", {dest[k], pout[k]}, {e[PO-1 -: NW], e});
                    end
                    pop_cyc[k] = cyc;
                    n_pops[k]++;
                end
                stall_prev[k] = vout[k] && !rdy_in[k];
                prev_out[k]   = {dest[k], pout[k]};
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p0, p1;
        for (int k = 0; k < 2; k++) begin
            pin[k] = '0; vin[k] = 1'b0; rdy_in[k] = 1'b1; rdy_mode[k] = 0;
            m_rd[k] = 0; m_wr[k] = 0; m_drop[k] = 0; n_pops[k] = 0;
            acc_cyc[k] = 0; pop_cyc[k] = 0; stall_prev[k] = 1'b0; prev_out[k] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", 64'(vout[k]), 64'd0);
            chk("rst_packed", 64'(pout[k]), 64'd0);
            chk("rst_dest", 64'(dest[k]), 64'd0);
            chk("rst_ready", 64'(rdy_out[k]), 64'd0);
            chk("rst_counts", {16'd0, rdc[k], wrc[k], drc[k]}, 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(rdy_out[0]), 64'd1);

        // Preload every word so all later reads have defined data
        fork
            for (int a = 0; a < MD; a++) send(0, 1'b1, 1'b0, 4'd0, AW'(a), W'($urandom_range(0, 255)));
            for (int a = 0; a < MD; a++) send(1, 1'b1, 1'b0, 4'd0, AW'(a), W'($urandom_range(0, 255)));
        join
        wait_drain();

        // Write then read, latency measured from read accept
        p0 = n_pops[0];
        send(0, 1'b1, 1'b0, 4'd2, 7'd3, 8'h5A);
        send(0, 1'b0, 1'b1, 4'd7, 7'd3, 8'h00);
        wait_drain();
        chk("rd_latency", 64'(pop_cyc[0] - acc_cyc[0]), 64'(LAT));
        chk("one_rsp", 64'(n_pops[0] - p0), 64'd1);

        // Backpressure: credits run out after RSP_DEPTH reads
        p0 = n_pops[0];
        rdy_mode[0] = 1;
        for (int i = 0; i < RD; i++) send(0, 1'b0, 1'b1, NW'(i), AW'($urandom_range(0, MD-1)), 8'h00);
        chk("ready_low_full", 64'(rdy_out[0]), 64'd0);
        chk("valid_held", 64'(vout[0]), 64'd1);
        rdy_mode[0] = 0;
        for (int i = 0; i < 2; i++) send(0, 1'b0, 1'b1, NW'(i + 8), AW'($urandom_range(0, MD-1)), 8'h00);
        wait_drain();
        chk("ten_rsps", 64'(n_pops[0] - p0), 64'd10);

        // Read-before-write
        send(0, 1'b1, 1'b0, 4'd1, 7'd9, 8'h11);
        send(0, 1'b1, 1'b1, 4'd3, 7'd9, 8'h22);
        send(0, 1'b0, 1'b1, 4'd3, 7'd9, 8'h00);
        wait_drain();
        chk("rd_count", 64'(rdc[0]), 64'(m_rd[0]));
        chk("wr_count", 64'(wrc[0]), 64'(m_wr[0]));

        // Write acknowledgements only on the WR_ACK instance
        p0 = n_pops[0];
        p1 = n_pops[1];
        fork
            begin send(0, 1'b1, 1'b0, 4'd4, 7'd20, 8'hA0); send(0, 1'b1, 1'b0, 4'd4, 7'd21, 8'hA1); end
            begin send(1, 1'b1, 1'b0, 4'd4, 7'd20, 8'hA0); send(1, 1'b1, 1'b0, 4'd4, 7'd21, 8'hA1); end
        join
        wait_drain();
        chk("no_ack_rsps", 64'(n_pops[0] - p0), 64'd0);
        chk("ack_rsps", 64'(n_pops[1] - p1), 64'd2);

        // Drop
        p0 = n_pops[0];
        send(0, 1'b0, 1'b0, 4'd5, 7'd1, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        chk("drop_count", 64'(drc[0]), 64'(m_drop[0]));
        chk("drop_no_rsp", 64'(n_pops[0] - p0), 64'd0);
        chk("drop_credits", 64'(u_dut0.credit_q), 64'(RD));

        // Random traffic with random backpressure
        rdy_mode[0] = 2;
        rdy_mode[1] = 2;
        fork
            for (int i = 0; i < 150; i++) rand_op(0);
            for (int i = 0; i < 150; i++) rand_op(1);
        join
        rdy_mode[0] = 0;
        rdy_mode[1] = 0;
        wait_drain();
        for (int k = 0; k < 2; k++) begin
            chk("rand_rd_count", 64'(rdc[k]), 64'(m_rd[k]));
            chk("rand_wr_count", 64'(wrc[k]), 64'(m_wr[k]));
            chk("rand_drop_count", 64'(drc[k]), 64'(m_drop[k]));
        end

        // Reset with reads in flight and responses queued
        rdy_mode[0] = 1;
        for (int i = 0; i < 5; i++) send(0, 1'b0, 1'b1, 4'd6, AW'(i), 8'h00);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(vout[0]), 64'd0);
        chk("rst_mid_packed", 64'(pout[0]), 64'd0);
        exp_q0.delete();
        exp_q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_rd[k] = 0; m_wr[k] = 0; m_drop[k] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_mid_ready", 64'(rdy_out[0]), 64'd0);
        rst = 1'b0;
        rdy_mode[0] = 0;
        @(posedge clk); #1;
        chk("rst_credits", 64'(u_dut0.credit_q), 64'(RD));
        chk("rst_ready_back", 64'(rdy_out[0]), 64'd1);
        chk("rst_counts_clr", {16'd0, rdc[0], wrc[0], drc[0]}, 64'd0);
        p0 = n_pops[0];
        send(0, 1'b0, 1'b1, 4'd8, 7'd9, 8'h00);
        wait_drain();
        chk("post_rst_read", 64'(n_pops[0] - p0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_pipelined.md
Name: ram_pipelined

Overview:
- Next-generation NoC-attached memory endpoint; successor to the single-port traffic RAM.
- Sits behind a depacketizer on the RAM node and feeds a packetizer; serves read/write requests from up to N source nodes.
- Adds a parametrised read latency, a response FIFO with credit-reserved acceptance (no response is ever dropped), optional write acknowledgements, read-and-write requests, and statistics counters.

Parameters:
- WIDTH, 8, data word width.
- ADDR_WIDTH, 7, word address width; memory depth = 2**ADDR_WIDTH.
- N, 16, number of NoC nodes.
- N_ADDR_WIDTH, $clog2(N), node id width.
- NODE, 15, this endpoint's node id (informational; drives nothing).
- RD_LAT, 2, read pipeline latency in cycles (legal 1..4).
- RSP_DEPTH, 8, response FIFO entries (power of 2, >= RD_LAT).
- WR_ACK, 0, when 1 every write produces a response.
- PACKED_IN, WIDTH+ADDR_WIDTH+N_ADDR_WIDTH+2, request width.
- PACKED_OUT, WIDTH+N_ADDR_WIDTH, response width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- i_packed_in  in  PACKED_IN  request, MSB->LSB {wr, rd, src, addr, wdata}.
- i_valid_in  in  1  request valid.
- i_ready_out  out  1  request accepted when valid&&ready.
- o_packed_out  out  PACKED_OUT  response {src, data}.
- o_dest_out  out  N_ADDR_WIDTH  response destination (= src).
- o_valid_out  out  1  response valid.
- o_ready_in  in  1  downstream ready.
- o_rd_count, o_wr_count, o_drop_count  out  16 each  saturating statistics.

Behaviour:
- Reset (async assert, sync release): o_valid_out=0, o_packed_out=0, o_dest_out=0, FIFO empty, read pipeline cleared, counters 0, i_ready_out=0 while rst is high. Memory contents are not reset. Reset mid-operation discards in-flight reads and queued responses.
- Credits: credits = RSP_DEPTH - (reads in pipeline + FIFO occupancy).
  - i_ready_out = 1 when credits > 0; combinational from registered state only, never from i_valid_in.
  - An accepted request that generates a response (rd=1, or wr=1 with WR_ACK=1) consumes 1 credit. A pop returns 1 credit.
  - Accept and pop in the same cycle leave credits unchanged.
- Write (wr=1): mem[addr] <= wdata on the accept cycle. With WR_ACK=1, a response {src, wdata} enters the pipeline with the same RD_LAT latency.
- Read (rd=1): mem[addr] is sampled on the accept cycle. The response enters the FIFO RD_LAT cycles after accept; earliest o_valid_out is at accept + RD_LAT when the FIFO was empty (fall-through from the pipeline tail not permitted; FIFO write then registered output).
- rd=1 and wr=1: read-before-write. The response carries old data; the memory takes the new data. Counts as one read and one write; generates one response.
- rd=0 and wr=0: request accepted and dropped; o_drop_count increments; no credit consumed.
- Same-address back-to-back: write at cycle t then read at t+1 returns the new data. Read at t with write at t+1 returns the old data.
- Output: o_valid_out = FIFO not empty; o_packed_out and o_dest_out are driven from the FIFO head and held stable while o_valid_out && !o_ready_in. Pop on o_valid_out && o_ready_in.
- FIFO: circular, wrap-around pointers with extra MSB for full/empty. Push into a full FIFO is impossible by construction; the bench asserts this.
- Counters saturate at 16'hFFFF.

Decomposition:
- Package ram_pkg: packed-request field offsets/widths, response struct typedef, RD_LAT bounds check constant.
- One sub-module: ram_rsp_fifo (parametrised synchronous FIFO, WIDTH=PACKED_OUT, DEPTH=RSP_DEPTH, count output).
- Read pipeline and credit counter stay in the top module.

Test Plan:
- Write 0x5A to addr 3 from src 2, then read addr 3 from src 7 (RD_LAT=2) -> exactly one response {7, 0x5A} with o_dest_out=7, o_valid_out rising 2 cycles after read accept.
- Hold o_ready_in=0 and issue 10 reads with RSP_DEPTH=8 -> i_ready_out drops after the 8th accept, no response is lost. Release o_ready_in -> 8 responses in order, then 2 more.
- rd=1, wr=1, addr 9 (old 0x11, new 0x22) followed by a read of addr 9 -> responses 0x11 then 0x22; o_rd_count=2, o_wr_count=1.
- WR_ACK=1: writes of 0xA0 and 0xA1 from src 4 -> two responses {4,0xA0}, {4,0xA1}. With WR_ACK=0 -> none.
- rd=0, wr=0 request -> no response; o_drop_count=1; credits unchanged.
- Assert rst with 3 reads in flight and 2 responses queued -> o_valid_out=0 immediately; after release credits=RSP_DEPTH; an earlier write is still readable.
